// File: rtl/dmux_4_way_16_buffered.sv
// Registered 4-way demultiplexer: one input word per cycle is steered by `select`
// into one of four single-entry holding registers, each with its own valid/ready handshake.
module dmux_4_way_16_buffered #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  localparam int NUM_CH = 4;

  chan_state_e      state_q [NUM_CH];
  chan_state_e      state_d [NUM_CH];
  logic [WIDTH-1:0] data_q  [NUM_CH];
  logic [WIDTH-1:0] data_d  [NUM_CH];

  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;
  logic              accept;

  always_comb begin
    ch_ready = {d_ready, c_ready, b_ready, a_ready};
    for (int i = 0; i < NUM_CH; i++) begin
      ch_valid[i] = (state_q[i] == FULL);
    end
  end

  // Only the addressed channel can stall the input; a full channel may still
  // take a new word in the same cycle its consumer drains the old one.
  always_comb begin
    in_ready = !ch_valid[select] || ch_ready[select];
    accept   = in_valid && in_ready;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      load[i]  = accept && (select == 2'(i));
      drain[i] = ch_valid[i] && ch_ready[i];
    end
  end

  // NOTE: every output of this block gets its default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      case (state_q[i])
        EMPTY: begin
          if (load[i]) begin
            state_d[i] = FULL;
            data_d[i]  = in;
          end
        end
        FULL: begin
          if (load[i]) begin
            data_d[i] = in;
          end else if (drain[i]) begin
            state_d[i] = EMPTY;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  // NOTE: the holding registers are cleared on reset, not just the valid flags,
  // so the data outputs read as zero straight out of reset.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  assign a       = data_q[0];
  assign b       = data_q[1];
  assign c       = data_q[2];
  assign d       = data_q[3];
  assign a_valid = ch_valid[0];
  assign b_valid = ch_valid[1];
  assign c_valid = ch_valid[2];
  assign d_valid = ch_valid[3];

endmodule

// File: tb/tb_dmux_4_way_16_buffered.sv
// Directed bench for dmux_4_way_16_buffered: words are queued per channel when
// driven and popped when the channel handshake delivers them.
module tb_dmux_4_way_16_buffered;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       select;
  logic [WIDTH-1:0] a, b, c, d;
  logic             a_valid, b_valid, c_valid, d_valid;
  logic             a_ready, b_ready, c_ready, d_ready;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q [4][$];

  dmux_4_way_16_buffered #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .select   (select),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .c_valid  (c_valid),
    .d_valid  (d_valid),
    .a_ready  (a_ready),
    .b_ready  (b_ready),
    .c_ready  (c_ready),
    .d_ready  (d_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word; the bench states whether it must be accepted this cycle.
  task automatic offer(input logic [1:0] sel, input logic [WIDTH-1:0] word, input logic exp_rdy);
    select   = sel;
    in       = word;
    in_valid = 1'b1;
    #1;
    check($sformatf("in_ready_sel%0d_%04h", sel, word), 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy) exp_q[sel].push_back(word);
  endtask

  // Delivery monitor: sampled at the falling edge, when the handshake for the
  // next rising edge is already settled.
  always @(negedge clk) begin
    logic [3:0]       v;
    logic [3:0]       r;
    logic [WIDTH-1:0] o [4];
    v = {d_valid, c_valid, b_valid, a_valid};
    r = {d_ready, c_ready, b_ready, a_ready};
    o[0] = a; o[1] = b; o[2] = c; o[3] = d;
    if (reset_n) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && r[i]) begin
          check($sformatf("deliver_pending_ch%0d", i), 32'(exp_q[i].size() > 0), 32'd1);
          if (exp_q[i].size() > 0) begin
            check($sformatf("deliver_data_ch%0d", i), 32'(o[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    in       = '0;
    in_valid = 1'b0;
    select   = 2'd0;
    {a_ready, b_ready, c_ready, d_ready} = 4'b0;
    tick();
    tick();
    reset_n = 1'b1;
    check("reset_valids", 32'({a_valid, b_valid, c_valid, d_valid}), 32'd0);
    check("reset_a", 32'(a), 32'd0);
    check("reset_d", 32'(d), 32'd0);
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      #1;
      check($sformatf("reset_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end

    // Single route into c with the consumer stalled.
    offer(2'd2, 16'h1234, 1'b1);
    tick();
    in_valid = 1'b0;
    check("route_c_data", 32'(c), 32'h1234);
    check("route_c_valid", 32'(c_valid), 32'd1);
    check("route_others_idle", 32'({a_valid, b_valid, d_valid}), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_c_hold_%0d", k), 32'({c_valid, c}), 32'h1_1234);
    end

    // Backpressure isolation: c blocks, a does not.
    offer(2'd2, 16'hBEEF, 1'b0);
    tick();
    check("blocked_c_unchanged", 32'(c), 32'h1234);
    offer(2'd0, 16'h0A0A, 1'b1);
    tick();
    in_valid = 1'b0;
    check("iso_a_data", 32'(a), 32'h0A0A);
    check("iso_a_valid", 32'(a_valid), 32'd1);
    check("iso_c_still", 32'({c_valid, c}), 32'h1_1234);

    // Drain a and c; contents remain, valid clears.
    a_ready = 1'b1;
    c_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    c_ready = 1'b0;
    check("drain_valids", 32'({a_valid, c_valid}), 32'd0);
    check("drain_c_contents", 32'(c), 32'h1234);

    // Full-rate pass-through into d.
    d_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      offer(2'd3, 16'(k), 1'b1);
      tick();
      check($sformatf("pass_d_%0d", k), 32'({d_valid, d}), 32'h1_0000 | 32'(k));
    end
    in_valid = 1'b0;
    tick();
    d_ready = 1'b0;
    check("pass_d_empty", 32'(d_valid), 32'd0);

    // Simultaneous drain and reload on b.
    offer(2'd1, 16'h5555, 1'b1);
    tick();
    in_valid = 1'b0;
    check("reload_b_first", 32'({b_valid, b}), 32'h1_5555);
    b_ready = 1'b1;
    offer(2'd1, 16'hAAAA, 1'b1);
    tick();
    in_valid = 1'b0;
    b_ready  = 1'b0;
    check("reload_b_second", 32'({b_valid, b}), 32'h1_AAAA);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("reload_b_drained", 32'(b_valid), 32'd0);

    // Mid-stream asynchronous reset discards a buffered word.
    offer(2'd0, 16'h7777, 1'b1);
    tick();
    in_valid = 1'b0;
    check("pre_reset_a_valid", 32'(a_valid), 32'd1);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    #1;
    check("async_reset_a", 32'({a_valid, a}), 32'd0);
    check("async_reset_bcd", 32'({b, c, d}), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      #1;
      check($sformatf("post_reset_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end
    tick();
    check("post_reset_no_valid", 32'({a_valid, b_valid, c_valid, d_valid}), 32'd0);

    // Rotation across stalled channels, then a fifth word to full a.
    for (int s = 0; s < 4; s++) begin
      offer(2'(s), 16'((s + 1) << 8), 1'b1);
      tick();
    end
    offer(2'd0, 16'h0500, 1'b0);
    in_valid = 1'b0;
    check("rot_valids", 32'({a_valid, b_valid, c_valid, d_valid}), 32'hF);
    check("rot_ab", {a, b}, 32'h0100_0200);
    check("rot_cd", {c, d}, 32'h0300_0400);
    {a_ready, b_ready, c_ready, d_ready} = 4'hF;
    tick();
    {a_ready, b_ready, c_ready, d_ready} = 4'h0;
    check("rot_drained", 32'({a_valid, b_valid, c_valid, d_valid}), 32'd0);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("queue_empty_ch%0d", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmux_4_way_16_buffered.md
Name: dmux_4_way_16_buffered

Overview:
- Registered 4-way, 16-bit demultiplexer: the routing counterpart of the 4-way 16-bit mux.
- Accepts one word per cycle on a valid/ready input and steers it to one of four output channels selected by `select`.
- Each output channel owns a one-entry holding register with its own valid/ready handshake, so a stalled consumer blocks only words addressed to it.
- Sits between the ALU/memory datapath and per-destination consumers (A/D/M register write paths, I/O).

Parameters:
- WIDTH, 16, data width of the input and of each output channel.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in  input  WIDTH  input data word
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid is also high
- select  input  2  destination channel: 0=a, 1=b, 2=c, 3=d; sampled with in
- a, b, c, d  output  WIDTH  channel holding-register contents
- a_valid, b_valid, c_valid, d_valid  output  1  channel register holds an undelivered word
- a_ready, b_ready, c_ready, d_ready  input  1  channel consumer accepts the word this cycle

Behaviour:
- Reset, asynchronous on reset_n low:
  - all four holding registers clear to 0;
  - all x_valid clear to 0;
  - in_ready then follows its combinational equation.
- Reset asserted mid-operation discards any buffered words. Nothing is delivered after reset release until new input is accepted.
- Per-channel state is a 2-state machine, EMPTY (x_valid=0) and FULL (x_valid=1):
  - EMPTY -> FULL on an input accept with select = x.
  - FULL -> EMPTY on drain (x_valid & x_ready) when there is no accept to x in the same cycle.
  - FULL -> FULL on drain plus accept to x in the same cycle: the register reloads with the new word and x_valid stays 1 (pass-through at full rate).
  - FULL -> FULL on accept to x without drain cannot happen, because in_ready is low in that case.
- in_ready (combinational, no dependence on in_valid):
  - in_ready = !x_valid[select] | x_ready[select].
  - It depends only on the addressed channel. Other channels being full or stalled never blocks the input.
- Accept:
  - Occurs when in_valid & in_ready.
  - On the next rising edge, register[select] <= in and x_valid[select] <= 1.
  - Latency input -> output valid is 1 cycle.
- Non-selected channels hold their data and valid on any accept cycle. They may drain independently in the same cycle.
- Drain leaves the register contents unchanged; only x_valid clears, unless the register is reloaded in the same cycle.
- Output data is stable while x_valid=1 && x_ready=0. A word is never overwritten before it is delivered.
- in_valid low: no state change except drains.
- `select` is meaningful only while in_valid=1. While in_valid=0, changes on `select` affect in_ready only; no state changes.
- Throughput:
  - one word/cycle sustained into a single channel whose ready is held high;
  - one word/cycle when select rotates across channels regardless of their ready, until an addressed channel is full and stalled.
- Ordering: words to the same channel are delivered in acceptance order. No ordering is guaranteed across channels.
- All outputs are registered except in_ready. No combinational path from in to any output.

Test Plan:
- Reset: drive reset_n=0 mid-stream with a_valid=1 -> a..d = 0x0000, all x_valid=0 immediately (asynchronous); after release in_ready=1 for every select.
- Single route: select=2, in=0x1234, in_valid=1 for one cycle, c_ready=0 -> next cycle c=0x1234, c_valid=1; a_valid, b_valid, d_valid stay 0; c holds 0x1234 for 5 stall cycles.
- Backpressure isolation:
  - c full with c_ready=0; then select=2, in=0xBEEF -> in_ready=0, c remains 0x1234.
  - Switch to select=0, in=0x0A0A -> in_ready=1; next cycle a=0x0A0A, a_valid=1.
- Pass-through: select=3, d_ready=1, in=0x0001..0x0008 on consecutive cycles -> in_ready=1 every cycle; d shows 0x0001..0x0008 one cycle later, d_valid continuously 1, no gaps.
- Simultaneous drain and reload: b holding 0x5555, b_ready=1 and accept in=0xAAAA with select=1 in the same cycle -> next cycle b=0xAAAA, b_valid=1; 0x5555 counted as delivered exactly once.
- Rotation: select 0,1,2,3 on successive cycles with all x_ready=0, in=0x0100,0x0200,0x0300,0x0400 -> all four accepted; a..d = 0x0100..0x0400, all valid; a fifth word with select=0 sees in_ready=0.
